// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the clocked control sequencer: opcode constants,
// decode field positions, the control word and the sequencer state.
package ctrl_seq_pkg;

    // Decode field positions inside Instruction (fixed; IW must be >= 8)
    localparam int JMP_HI = 2;   // Instruction[2:0] selects shift-right-logical / jump
    localparam int BR_HI  = 3;   // Instruction[3:0] all ones enables branch
    localparam int FN_HI  = 5;   // Instruction[5:4] general-register function
    localparam int FN_LO  = 4;
    localparam int OP_HI  = 7;   // Instruction[7:6] major opcode
    localparam int OP_LO  = 6;

    // Opcode constants
    localparam logic [2:0] kSRL  = 3'b101;
    localparam logic [1:0] kGROP = 2'b01;
    localparam logic [1:0] kGFN  = 2'b11;
    localparam logic [1:0] kMEM  = 2'b10;

    // Decoded control word
    typedef struct packed {
        logic jump;
        logic branch_en;
        logic gen_reg_en;
        logic mem_op;
    } ctrl_t;

    // Sequencer state
    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Counter width for a counter that must hold values up to n-1, never zero bits wide
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational instruction decoder. Usable on its own as a golden
// reference for the control word.
module ctrl_decode
    import ctrl_seq_pkg::*;
#(
    parameter int IW = 9
) (
    input  logic [IW-1:0] instr,
    output ctrl_t         ctrl
);

    assign ctrl.jump       = (instr[JMP_HI:0] == kSRL);
    assign ctrl.branch_en  = &instr[BR_HI:0];
    assign ctrl.gen_reg_en = !((instr[OP_HI:OP_LO] == kGROP) && (instr[FN_HI:FN_LO] != kGFN));
    assign ctrl.mem_op     = (instr[OP_HI:OP_LO] == kMEM);

    // Bits above the decode fields are reserved and deliberately ignored
    if (IW > 8) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^instr[IW-1:8];
    end

endmodule

// File: rtl/ctrl_seq.sv
// Clocked control sequencer: decodes accepted instructions into a registered
// control word behind a valid/ready handshake, drops the instructions that
// follow a jump, and stalls fetch while a memory operation completes.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int IW           = 9,
    parameter int SQUASH_SLOTS = 1,
    parameter int MEM_CYCLES   = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          InstrValid,
    input  logic [IW-1:0] Instruction,
    output logic          InstrReady,
    output logic          CtrlValid,
    input  logic          CtrlReady,
    output logic          Jump,
    output logic          BranchEn,
    output logic          GenRegEn,
    output logic          MemOp,
    output logic          Busy
);

    localparam int SQ_W = cnt_w(SQUASH_SLOTS + 1);
    localparam int WT_W = cnt_w(MEM_CYCLES);

    state_t          state;
    ctrl_t           ctrl_q;
    ctrl_t           dec;
    logic [SQ_W-1:0] sq_cnt;
    logic [WT_W-1:0] wait_cnt;
    logic            accept;

    ctrl_decode #(.IW(IW)) u_decode (
        .instr (Instruction),
        .ctrl  (dec)
    );

    // Handshake: accept only in RUN and when the output slot is free or being drained
    assign InstrReady = (state == RUN) && (!CtrlValid || CtrlReady);
    assign accept     = InstrValid && InstrReady;

    assign Jump     = ctrl_q.jump;
    assign BranchEn = ctrl_q.branch_en;
    assign GenRegEn = ctrl_q.gen_reg_en;
    assign MemOp    = ctrl_q.mem_op;
    assign Busy     = (state == WAIT) || (sq_cnt != '0);

    // FSM, squash/wait counters and the registered control word
    // NOTE: every register here is assigned with <= so all of them see the pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= RUN;
            CtrlValid <= 1'b0;
            ctrl_q    <= '0;
            sq_cnt    <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        if (sq_cnt != '0) begin
                            // Squash slot: drop the instruction, only retire the old word
                            sq_cnt    <= sq_cnt - 1'b1;
                            CtrlValid <= CtrlValid && !CtrlReady;
                        end else begin
                            ctrl_q    <= dec;
                            CtrlValid <= 1'b1;
                            if (dec.jump && (SQUASH_SLOTS > 0))
                                sq_cnt <= SQ_W'(SQUASH_SLOTS);
                            if (dec.mem_op && (MEM_CYCLES > 1)) begin
                                state    <= WAIT;
                                wait_cnt <= WT_W'(MEM_CYCLES - 1);
                            end
                        end
                    end else if (CtrlValid && CtrlReady) begin
                        CtrlValid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (CtrlValid && CtrlReady)
                        CtrlValid <= 1'b0;
                    wait_cnt <= (wait_cnt != '0) ? wait_cnt - 1'b1 : '0;
                    if (wait_cnt <= WT_W'(1))
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq (IW=9, SQUASH_SLOTS=1, MEM_CYCLES=2).
// A transaction-level model tracks when fetch reopens (as an absolute cycle
// number) and how many accepts remain to be dropped; a negedge process compares
// every output against it, and directed points pin literal values.
module tb_ctrl_seq;

    localparam int IW    = 9;
    localparam int SLOTS = 1;
    localparam int MEMC  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic          instr_ready;
    logic          ctrl_valid;
    logic          ctrl_ready;
    logic          jump, branch_en, gen_reg_en, mem_op, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_seq #(.IW(IW), .SQUASH_SLOTS(SLOTS), .MEM_CYCLES(MEMC)) dut (
        .Clk         (clk),
        .Reset       (rst_n),
        .InstrValid  (instr_valid),
        .Instruction (instr),
        .InstrReady  (instr_ready),
        .CtrlValid   (ctrl_valid),
        .CtrlReady   (ctrl_ready),
        .Jump        (jump),
        .BranchEn    (branch_en),
        .GenRegEn    (gen_reg_en),
        .MemOp       (mem_op),
        .Busy        (busy)
    );

    // ---------------- model ----------------
    int       cyc        = 0;   // edges seen so far
    int       open_at    = 0;   // first cycle number at which fetch is open again
    int       drop_left  = 0;   // accepts still to be discarded after a jump
    bit       m_cv       = 0;
    bit [3:0] m_word     = '0;  // {jump, branch_en, gen_reg_en, mem_op}
    bit       m_en       = 0;

    function automatic bit [3:0] decode(input logic [IW-1:0] i);
        bit j, b, g, m;
        j = (i[2:0] == 3'b101);
        b = (i[3:0] == 4'hF);
        g = !((i[7:6] == 2'b01) && (i[5:4] != 2'b11));
        m = (i[7:6] == 2'b10);
        return {j, b, g, m};
    endfunction

    function automatic bit m_ready();
        return (cyc >= open_at) && (!m_cv || ctrl_ready);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge
    task automatic step(input bit rst, input bit v, input logic [IW-1:0] ins, input bit cr);
        bit       acc;
        int       n_open, n_drop;
        bit       n_cv;
        bit [3:0] n_word, d;
        rst_n = rst; instr_valid = v; instr = ins; ctrl_ready = cr;
        acc    = v && m_ready();
        n_open = open_at; n_drop = drop_left; n_cv = m_cv; n_word = m_word;
        d      = decode(ins);
        if (!rst) begin
            n_open = 0; n_drop = 0; n_cv = 0; n_word = '0;
        end else if (acc) begin
            if (drop_left > 0) begin
                n_drop = drop_left - 1;
                n_cv   = 0;
            end else begin
                n_word = d;
                n_cv   = 1;
                if (d[3]) n_drop = SLOTS;
                if (d[0] && MEMC > 1) n_open = cyc + MEMC;
            end
        end else if (m_cv && cr) begin
            n_cv = 0;
        end
        @(posedge clk);
        cyc++;
        open_at = n_open; drop_left = n_drop; m_cv = n_cv; m_word = n_word;
        #1;
    endtask

    // Compare every output against the model once per cycle
    always @(negedge clk) begin
        if (m_en) begin
            check("InstrReady", instr_ready, m_ready());
            check("CtrlValid",  ctrl_valid,  m_cv);
            check("Busy",       busy,        (cyc < open_at) || (drop_left != 0));
            check("Jump",       jump,        m_word[3]);
            check("BranchEn",   branch_en,   m_word[2]);
            check("GenRegEn",   gen_reg_en,  m_word[1]);
            check("MemOp",      mem_op,      m_word[0]);
        end
    end

    typedef struct {
        bit            v;
        logic [IW-1:0] ins;
        bit            cr;
    } vec_t;

    vec_t tbl [14] = '{
        '{1, 9'h0F5, 1}, '{1, 9'h1FF, 0}, '{0, 9'h000, 1}, '{1, 9'h0B0, 1},
        '{1, 9'h04F, 1}, '{1, 9'h07D, 0}, '{1, 9'h07D, 1}, '{0, 9'h085, 0},
        '{1, 9'h085, 1}, '{1, 9'h00F, 1}, '{1, 9'h00F, 0}, '{1, 9'h0C3, 1},
        '{0, 9'h0C3, 1}, '{1, 9'h180, 1}
    };

    initial begin
        rst_n = 0; instr_valid = 0; instr = '0; ctrl_ready = 1;

        // Reset
        step(0, 0, 9'h000, 1);
        m_en = 1;
        step(0, 0, 9'h000, 1);
        check("rst CtrlValid",  ctrl_valid,  0);
        check("rst InstrReady", instr_ready, 1);
        check("rst Busy",       busy,        0);
        check("rst Jump",       jump,        0);

        // Back-to-back branch-enable instructions
        step(1, 1, 9'h00F, 1);
        check("br BranchEn", branch_en, 1);
        check("br CtrlValid", ctrl_valid, 1);
        check("br Jump", jump, 0);
        step(1, 1, 9'h00F, 1);
        step(1, 1, 9'h00F, 1);
        check("br CtrlValid2", ctrl_valid, 1);

        // Jump then one squashed instruction
        step(1, 1, 9'h005, 1);
        check("jmp Jump", jump, 1);
        check("jmp Busy", busy, 1);
        step(1, 1, 9'h00F, 1);
        check("squash CtrlValid", ctrl_valid, 0);
        check("squash Busy", busy, 0);
        step(1, 1, 9'h00F, 1);
        check("post-squash BranchEn", branch_en, 1);
        check("post-squash CtrlValid", ctrl_valid, 1);

        // Memory op: one wait cycle, next accept two cycles later
        step(1, 1, 9'h080, 1);
        check("mem MemOp", mem_op, 1);
        check("mem InstrReady", instr_ready, 0);
        check("mem Busy", busy, 1);
        step(1, 1, 9'h00F, 1);
        check("mem done InstrReady", instr_ready, 1);
        check("mem consumed CtrlValid", ctrl_valid, 0);
        step(1, 1, 9'h00F, 1);
        check("mem next BranchEn", branch_en, 1);

        // Downstream stall for three cycles
        step(1, 1, 9'h080, 0);
        step(1, 1, 9'h080, 0);
        step(1, 1, 9'h080, 0);
        check("stall InstrReady", instr_ready, 0);
        check("stall BranchEn", branch_en, 1);
        check("stall MemOp", mem_op, 0);
        step(1, 1, 9'h080, 1);
        check("release MemOp", mem_op, 1);

        // Reset in the middle of WAIT
        step(1, 0, 9'h000, 1);
        step(1, 1, 9'h080, 1);
        step(0, 1, 9'h00F, 1);
        check("midwait CtrlValid", ctrl_valid, 0);
        check("midwait InstrReady", instr_ready, 1);
        check("midwait Busy", busy, 0);

        // General-register enable
        step(1, 1, 9'h070, 1);
        check("grop GenRegEn1", gen_reg_en, 1);
        step(1, 1, 9'h040, 1);
        check("grop GenRegEn0", gen_reg_en, 0);

        // Jump and memory op together; squash applies after WAIT
        step(1, 1, 9'h085, 1);
        check("jm Jump", jump, 1);
        check("jm MemOp", mem_op, 1);
        step(1, 1, 9'h00F, 1);
        check("jm wait Busy", busy, 1);
        step(1, 1, 9'h00F, 1);
        check("jm dropped CtrlValid", ctrl_valid, 0);
        step(1, 1, 9'h00F, 1);
        check("jm after BranchEn", branch_en, 1);

        // Jump inside a squash slot does not re-arm squash
        step(1, 1, 9'h005, 1);
        step(1, 1, 9'h005, 1);
        step(1, 1, 9'h00F, 1);
        check("slotjmp CtrlValid", ctrl_valid, 1);
        check("slotjmp Jump", jump, 0);

        // Mixed directed vectors, model-checked only
        foreach (tbl[k]) step(1, tbl[k].v, tbl[k].ins, tbl[k].cr);
        step(1, 0, 9'h000, 1);
        step(1, 0, 9'h000, 1);

        @(negedge clk);
        m_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
